alu_seq_control: RTL
====================

ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width (>=4, even).
REQ-002 SHALL have parameter DIV_EN, default 1, meaning 1 enables div/divu, 0 decodes them as illegal.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports op  in  6  ALU operation class from main control; funct  in  6  instruction funct field.
REQ-006 SHALL have port start  in  1  instruction issue strobe, qualifies op/funct for multi-cycle ops.
REQ-007 SHALL have ports a, b  in  WIDTH  rs/rt operand values.
REQ-008 SHALL have port control  out  4  ALU control code, combinational from op/funct.
REQ-009 SHALL have ports busy, done, stall  out  1 each; hi, lo  out  WIDTH  HI/LO registers.

Function
REQ-010 control SHALL decode: op 000000->0010, 000001->0110, 001101->0001, 001100->0000, 001001->0100, 001010->0111, 001011->1011, 001111->1010, 101001->1100, 101000->1101.
REQ-011 With op=000010 control SHALL decode funct: 100100->0000, 100101->0001, 100000/001000->0010, 100110->0011, 100001->0100, 100011->0101, 100010->0110, 101010->0111, 101011->1011, 001101->1111.
REQ-012 With op=000010: funct 011000 (mult)->1000, 011001 (multu)->1001, 011010 (div) and 011011 (divu)->1110 when DIV_EN=1, 010000 (mfhi)/010010 (mflo)->1110; every unlisted combination ->0000.
REQ-013 Sequencer states IDLE, MUL, DIV, DONE; only IDLE accepts start.
REQ-014 IDLE + start + mult/multu -> MUL; operands latched (signed: magnitudes, result-sign flag); counter=WIDTH.
REQ-015 IDLE + start + div/divu (DIV_EN=1), b!=0 -> DIV; same latching; counter=WIDTH.
REQ-016 MUL: one shift-add step per cycle; DIV: one restoring shift-subtract step per cycle; counter decrements each cycle; at counter==1 next state DONE.
REQ-017 On entry to DONE hi/lo SHALL be written: mult {hi,lo}=2*WIDTH-bit product; div lo=quotient, hi=remainder.
REQ-018 Signed results: product/quotient negated when operand signs differ; remainder takes dividend sign; min/-1 gives lo=min, hi=0.
REQ-019 Divide by zero: IDLE -> DONE directly on accepting edge, lo=all ones, hi=a.
REQ-020 DONE lasts exactly one cycle, then IDLE; done=1 only in DONE; busy=1 only in MUL/DIV.
REQ-021 Latency: accept edge to done high = WIDTH+1 cycles (divide-by-zero: 1 cycle); busy high exactly WIDTH cycles.
REQ-022 start while busy or in DONE SHALL be ignored (no queueing, no state change).
REQ-023 start with non-multi-cycle op/funct, or div/divu with DIV_EN=0, SHALL leave sequencer in IDLE.
REQ-024 stall SHALL equal (busy or DONE) AND op=000010 AND funct in {mfhi, mflo, mult, multu, div, divu}.
REQ-025 hi/lo SHALL hold value except on DONE entry; operand inputs may change freely after accept.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, counter=0, hi=lo=0, busy=done=0, overriding start.
REQ-027 rst mid-operation SHALL discard the partial result; hi/lo become 0, no done pulse.
REQ-028 control SHALL be unaffected by rst (pure decode).

Verification
REQ-029 op=000010 funct=100010 -> control=0110; op=001111 -> 1010; op=000010 funct=111111 -> 0000.
REQ-030 WIDTH=32 mult a=FFFFFFFD b=7 start -> busy 32 cycles, done cycle 33, hi=FFFFFFFF lo=FFFFFFEB.
REQ-031 divu a=100 b=7 -> lo=14 hi=2; div a=FFFFFFF9 b=2 -> lo=FFFFFFFD hi=FFFFFFFF.
REQ-032 div a=5 b=0 -> done one cycle after accept, lo=FFFFFFFF hi=5, busy never high.
REQ-033 multu accepted, second start at cycle 3 ignored, rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done.
REQ-034 mflo presented during busy -> stall=1; same after done -> stall=0, lo holds product.

Source files
------------

// File: rtl/alu_seq_if.sv
// Issue/result bundle between main control and the ALU control / multiply-divide sequencer.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       control;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output op, funct, start, a, b,
                  input  control, busy, done, stall, hi, lo);
  modport slave  (input  op, funct, start, a, b,
                  output control, busy, done, stall, hi, lo);
endinterface

// File: rtl/alu_seq_control.sv
// ALU control decode plus an iterative shift-add multiplier / restoring divider writing HI/LO.
module alu_seq_control #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int         CW      = $clog2(WIDTH + 1);
  localparam logic [5:0] OP_R    = 6'b000010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH-1:0]   dvs_q, hi_q, lo_q, quo, rem, a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic               neg_q, rneg_q, busy_q, done_q;
  logic               is_mul, is_div, sgn, sdiff;
  logic [3:0]         ctrl;

  always_comb begin
    ctrl = 4'b0000;
    case (bus.op)
      6'b000000: ctrl = 4'b0010;
      6'b000001: ctrl = 4'b0110;
      6'b001101: ctrl = 4'b0001;
      6'b001100: ctrl = 4'b0000;
      6'b001001: ctrl = 4'b0100;
      6'b001010: ctrl = 4'b0111;
      6'b001011: ctrl = 4'b1011;
      6'b001111: ctrl = 4'b1010;
      6'b101001: ctrl = 4'b1100;
      6'b101000: ctrl = 4'b1101;
      OP_R: begin
        case (bus.funct)
          6'b100100:         ctrl = 4'b0000;
          6'b100101:         ctrl = 4'b0001;
          6'b100000,
          6'b001000:         ctrl = 4'b0010;
          6'b100110:         ctrl = 4'b0011;
          6'b100001:         ctrl = 4'b0100;
          6'b100011:         ctrl = 4'b0101;
          6'b100010:         ctrl = 4'b0110;
          6'b101010:         ctrl = 4'b0111;
          6'b101011:         ctrl = 4'b1011;
          6'b001101:         ctrl = 4'b1111;
          F_MULT:            ctrl = 4'b1000;
          F_MULTU:           ctrl = 4'b1001;
          F_DIV, F_DIVU:     ctrl = DIV_EN ? 4'b1110 : 4'b0000;
          F_MFHI, F_MFLO:    ctrl = 4'b1110;
          default:           ctrl = 4'b0000;
        endcase
      end
      default: ctrl = 4'b0000;
    endcase
  end

  assign is_mul = (bus.op == OP_R) && (bus.funct == F_MULT || bus.funct == F_MULTU);
  assign is_div = DIV_EN && (bus.op == OP_R) && (bus.funct == F_DIV || bus.funct == F_DIVU);
  // Signed variants (mult, div) have an even funct code.
  assign sgn    = ~bus.funct[0];
  assign sdiff  = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  assign a_mag  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dvs_q : '0)};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, dvs_q};
    if (state_q == S_DIV)
      acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
    else
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  assign prod = neg_q  ? -acc_d : acc_d;
  assign quo  = neg_q  ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && is_mul) begin
            state_q <= S_MUL;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            dvs_q   <= a_mag;
            neg_q   <= sdiff;
          end else if (bus.start && is_div) begin
            if (bus.b == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              lo_q    <= '1;
              hi_q    <= bus.a;
            end else begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
              dvs_q   <= b_mag;
              neg_q   <= sdiff;
              rneg_q  <= sgn & bus.a[WIDTH-1];
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (state_q == S_MUL) begin
              {hi_q, lo_q} <= prod;
            end else begin
              lo_q <= quo;
              hi_q <= rem;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.control = ctrl;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.stall   = (busy_q || done_q) && (bus.op == OP_R) &&
                       (bus.funct == F_MFHI || bus.funct == F_MFLO || bus.funct == F_MULT ||
                        bus.funct == F_MULTU || bus.funct == F_DIV || bus.funct == F_DIVU);
endmodule
